// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : uart_pkg
//  Purpose   : Shared types and encodings for the UART TX/RX paths.
//              ST_BREAK exists only when UART_TX_BREAK_EN is defined.
//  Revision  : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Raw encodings of the parity_mode configuration input
    localparam logic [1:0] c_PARITY_MODE_NONE = 2'b00;
    localparam logic [1:0] c_PARITY_MODE_EVEN = 2'b01;
    localparam logic [1:0] c_PARITY_MODE_ODD  = 2'b10;

    typedef enum logic [1:0] {
        PARITY_NONE = c_PARITY_MODE_NONE,
        PARITY_EVEN = c_PARITY_MODE_EVEN,
        PARITY_ODD  = c_PARITY_MODE_ODD
    } parity_mode_e;

    // The state names the bit currently driven on the line
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
`ifdef UART_TX_BREAK_EN
        , ST_BREAK = 3'd6
`endif
    } tx_state_e;

    // The unused encoding 2'b11 behaves as "no parity"
    function automatic parity_mode_e decode_parity(input logic [1:0] mode);
        case (mode)
            c_PARITY_MODE_EVEN: return PARITY_EVEN;
            c_PARITY_MODE_ODD:  return PARITY_ODD;
            default:            return PARITY_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : sync_fifo
//  Purpose   : Single-clock FIFO, power-of-two depth. Read data is valid
//              combinationally while not empty; full/empty/count are
//              registered and reflect a push or pop one clock later.
//  Revision  : 1.0  initial release
// ============================================================================
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [c_AW:0]    w_count_next;

    // Requests are qualified here so callers may hold push/pop freely
    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !r_empty;

    // Occupancy after this clock; a simultaneous push and pop cancels out
    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : uart_tx_fifo
//  Purpose   : Buffered UART transmitter. Stream words are queued in a
//              sync_fifo and sent LSB-first on baud_tick with optional
//              even/odd parity and 1 or 2 stop bits, frames back-to-back.
//              Define UART_TX_BREAK_EN to add break_req and the BREAK state.
//  Revision  : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATABITS   = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_tick,
    input  logic [DATABITS-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    output logic                          tx_data,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                          break_req
`endif
);

    localparam int c_IDX_W = $clog2(DATABITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATABITS - 1);

    tx_state_e               r_state;
    logic [DATABITS-1:0]     r_shift;
    logic [c_IDX_W-1:0]      r_idx;
    logic                    r_par_en;
    logic                    r_par_bit;
    logic                    r_stop2;
    logic                    r_tx_data;
    logic                    r_tx_busy;

    logic [DATABITS-1:0]     w_fifo_rdata;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_frame_end;
    logic                    w_gap;
    logic                    w_break;
    logic                    w_pop;
    parity_mode_e            w_mode;

    sync_fifo #(
        .WIDTH (DATABITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_rdata),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

`ifdef UART_TX_BREAK_EN
    assign w_break = break_req;
`else
    assign w_break = 1'b0;
`endif

    assign w_mode      = decode_parity(parity_mode);
    // Last stop-bit period of a frame is on the line
    assign w_frame_end = ((r_state == ST_STOP1) && !r_stop2) || (r_state == ST_STOP2);
    // Tick at which a new frame (or break) may begin
    assign w_gap       = baud_tick && ((r_state == ST_IDLE) || w_frame_end);
    assign w_pop       = w_gap && !w_break && !w_fifo_empty;

    // Frame sequencer: every line change happens on a baud tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_tx_data <= 1'b1;
            r_tx_busy <= 1'b0;
        end else if (baud_tick) begin
            case (r_state)
                ST_START: begin
                    r_tx_data <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_idx     <= '0;
                    r_state   <= ST_DATA;
                end
                ST_DATA: begin
                    if (r_idx != c_LAST_IDX) begin
                        r_tx_data <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_idx     <= r_idx + 1'b1;
                    end else if (r_par_en) begin
                        r_tx_data <= r_par_bit;
                        r_state   <= ST_PARITY;
                    end else begin
                        r_tx_data <= 1'b1;
                        r_state   <= ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    r_tx_data <= 1'b1;
                    r_state   <= ST_STOP1;
                end
                ST_STOP1: begin
                    if (r_stop2) r_state <= ST_STOP2;
                end
`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    // One high period after break, then normal end of frame
                    if (!break_req) begin
                        r_tx_data <= 1'b1;
                        r_stop2   <= 1'b0;
                        r_state   <= ST_STOP1;
                    end
                end
`endif
                default: ;
            endcase

            // Frame boundary: break wins over queued data, otherwise chain or idle
            if (w_gap) begin
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    r_tx_data <= 1'b0;
                    r_tx_busy <= 1'b1;
                    r_state   <= ST_BREAK;
                end else
`endif
                if (w_pop) begin
                    r_shift   <= w_fifo_rdata;
                    r_par_en  <= (w_mode != PARITY_NONE);
                    r_par_bit <= (^w_fifo_rdata) ^ (w_mode == PARITY_ODD);
                    r_stop2   <= stop2;
                    r_tx_data <= 1'b0;
                    r_tx_busy <= 1'b1;
                    r_state   <= ST_START;
                end else if (r_state != ST_IDLE) begin
                    r_tx_busy <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            end
        end
    end

    assign s_ready = !w_fifo_full;
    assign tx_data = r_tx_data;
    assign tx_busy = r_tx_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : tb_uart_tx_fifo
//  Purpose   : Self-checking bench for uart_tx_fifo (DATABITS=8, depth 4,
//              baud tick every 4 clocks). Break sequence runs only when
//              UART_TX_BREAK_EN is defined.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       tx_data;
    logic       tx_busy;
    logic [2:0] fifo_count;
`ifdef UART_TX_BREAK_EN
    logic       break_req;
`endif

    logic       tick_en;
    int         tick_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    uart_tx_fifo #(
        .DATABITS   (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count)
`ifdef UART_TX_BREAK_EN
        ,
        .break_req   (break_req)
`endif
    );

    always #5 clk = ~clk;

    // One-clock baud pulse every 4 clocks, pausable by tick_en
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt  = (tick_cnt + 1) % 4;
            baud_tick = tick_en && (tick_cnt == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next clock edge carrying a baud tick, sample just after it
    task automatic next_tick_edge();
        int n;
        n = 0;
        @(posedge clk);
        while (!baud_tick && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (!baud_tick) check("tick_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pause_ticks();
        @(negedge clk);
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Directed frame vectors; exp_bits holds the line value per period,
    // period 0 in bit 11, read left to right.
    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  pm;
        logic        st2;
        logic [3:0]  nbits;
        logic [11:0] exp_bits;
    } vec_t;

    vec_t tv [6];

    initial begin
        bit q[$];

        tv[0] = '{data: 8'h55, pm: 2'b01, st2: 1'b0, nbits: 4'd11, exp_bits: 12'b0101_0101_0010};
        tv[1] = '{data: 8'hA3, pm: 2'b10, st2: 1'b1, nbits: 4'd12, exp_bits: 12'b0110_0010_1111};
        tv[2] = '{data: 8'h00, pm: 2'b00, st2: 1'b0, nbits: 4'd10, exp_bits: 12'b0000_0000_0100};
        tv[3] = '{data: 8'hFF, pm: 2'b11, st2: 1'b1, nbits: 4'd11, exp_bits: 12'b0111_1111_1110};
        tv[4] = '{data: 8'h80, pm: 2'b10, st2: 1'b0, nbits: 4'd11, exp_bits: 12'b0000_0000_1010};
        tv[5] = '{data: 8'h01, pm: 2'b01, st2: 1'b1, nbits: 4'd12, exp_bits: 12'b0100_0000_0111};

        reset       = 1'b1;
        s_data      = '0;
        s_valid     = 1'b0;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        tick_en     = 1'b1;
`ifdef UART_TX_BREAK_EN
        break_req   = 1'b0;
`endif

        // ---------------- reset idle ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_tx_data", tx_data, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        for (int i = 0; i < 10; i++) begin
            next_tick_edge();
            check($sformatf("idle_line_t%0d", i), tx_data, 1);
        end
        check("idle_tx_busy", tx_busy, 0);
        check("idle_s_ready", s_ready, 1);
        check("idle_fifo_count", fifo_count, 0);

        // ---------------- table-driven single frames ----------------
        for (int v = 0; v < 6; v++) begin
            parity_mode = tv[v].pm;
            stop2       = tv[v].st2;
            push_word(tv[v].data);
            check($sformatf("v%0d_count_after_push", v), fifo_count, 1);
            for (int i = 0; i < int'(tv[v].nbits); i++) begin
                next_tick_edge();
                check($sformatf("v%0d_bit%0d", v, i), tx_data, tv[v].exp_bits[11 - i]);
                check($sformatf("v%0d_busy%0d", v, i), tx_busy, 1);
                if (i == 0) begin
                    // Changing config mid-frame must not affect this frame
                    parity_mode = ~tv[v].pm;
                    stop2       = ~tv[v].st2;
                end
            end
            next_tick_edge();
            check($sformatf("v%0d_end_busy", v), tx_busy, 0);
            check($sformatf("v%0d_end_line", v), tx_data, 1);
        end

        // ---------------- backpressure and back-to-back ----------------
        parity_mode = 2'b00;
        stop2       = 1'b0;
        pause_ticks();
        for (int w = 1; w <= 4; w++) push_word(8'(w));
        check("bp_full_count", fifo_count, 4);
        check("bp_full_ready", s_ready, 0);
        @(negedge clk);
        s_data  = 8'h05;
        s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_fifth_held_ready", s_ready, 0);
            check("bp_fifth_held_count", fifo_count, 4);
        end
        q.delete();
        for (int w = 1; w <= 5; w++) begin
            logic [7:0] wv;
            wv = 8'(w);
            q.push_back(1'b0);
            for (int b = 0; b < 8; b++) q.push_back(wv[b]);
            q.push_back(1'b1);
        end
        tick_en = 1'b1;
        fork
            begin
                int n;
                n = 0;
                while (!s_ready && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_fifth_accepted", s_ready, 1);
                @(negedge clk);
                s_valid = 1'b0;
            end
            begin
                for (int i = 0; i < q.size(); i++) begin
                    next_tick_edge();
                    check($sformatf("bp_bit%0d", i), tx_data, q[i]);
                    check($sformatf("bp_busy%0d", i), tx_busy, 1);
                end
                next_tick_edge();
                check("bp_end_busy", tx_busy, 0);
                check("bp_end_count", fifo_count, 0);
            end
        join

        // ---------------- reset mid-frame ----------------
        pause_ticks();
        push_word(8'hF0);
        push_word(8'h11);
        push_word(8'h22);
        tick_en = 1'b1;
        next_tick_edge();
        check("mr_start", tx_data, 0);
        check("mr_count", fifo_count, 2);
        for (int i = 0; i < 4; i++) begin
            next_tick_edge();
            check($sformatf("mr_bit%0d", i), tx_data, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mr_line_high", tx_data, 1);
        check("mr_busy", tx_busy, 0);
        check("mr_flushed", fifo_count, 0);
        check("mr_ready", s_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            next_tick_edge();
            check($sformatf("mr_quiet_line%0d", i), tx_data, 1);
            check($sformatf("mr_quiet_busy%0d", i), tx_busy, 0);
        end

`ifdef UART_TX_BREAK_EN
        // ---------------- line break ----------------
        parity_mode = 2'b00;
        stop2       = 1'b0;
        pause_ticks();
        break_req = 1'b1;
        push_word(8'h33);
        tick_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_tick_edge();
            check($sformatf("brk_low%0d", i), tx_data, 0);
            check($sformatf("brk_busy%0d", i), tx_busy, 1);
            check($sformatf("brk_count%0d", i), fifo_count, 1);
        end
        @(negedge clk);
        break_req = 1'b0;
        next_tick_edge();
        check("brk_release_high", tx_data, 1);
        check("brk_release_busy", tx_busy, 1);
        q.delete();
        begin
            logic [7:0] bv;
            bv = 8'h33;
            q.push_back(1'b0);
            for (int b = 0; b < 8; b++) q.push_back(bv[b]);
            q.push_back(1'b1);
        end
        for (int i = 0; i < q.size(); i++) begin
            next_tick_edge();
            check($sformatf("brk_frame_bit%0d", i), tx_data, q[i]);
        end
        next_tick_edge();
        check("brk_end_busy", tx_busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, runtime-configurable UART transmitter. It is the next-generation TX path of the UART block. Bytes arrive on a valid/ready stream into an internal FIFO and are serialised LSB-first on a shared external baud tick. Frames go out back-to-back with selectable parity (none/even/odd) and 1 or 2 stop bits. It sits between the host-side register/stream logic and the TX pin, next to the existing baud generator.

## Interface
- DATABITS, 8, data bits per frame, legal 5..9
- FIFO_DEPTH, 16, FIFO entries, power of two, ≥2
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- baud_tick  in  1  one-clk pulse per bit period
- s_data  in  DATABITS  word to transmit
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept (= not full)
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- stop2  in  1  1 = two stop bits
- tx_data  out  1  serial line, idle high
- tx_busy  out  1  frame in progress
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words queued, excludes word on the line
- break_req  in  1  line-break request, present only with UART_TX_BREAK_EN

## Operation
- Push when s_valid && s_ready. s_ready is a registered signal equal to !full.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, plus BREAK with the macro. The state names the bit currently on the line.
- All state, bit-index and tx_data updates happen only on clock edges where baud_tick=1.
- IDLE, tick, FIFO non-empty: pop the word, latch the word, parity_mode and stop2, then tx_data<=0 → START, tx_busy<=1.
- START, tick: tx_data<=d[0], idx<=0 → DATA.
- DATA, tick, idx<DATABITS-1: tx_data<=d[idx+1], idx++.
- DATA, tick, idx==DATABITS-1:
  - parity on: tx_data<=parity → PARITY
  - parity off: tx_data<=1 → STOP1
- PARITY, tick: tx_data<=1 → STOP1.
- STOP1, tick, stop2 latched: → STOP2, line stays 1.
- STOP1 without stop2, or STOP2, tick: end of frame.
  - FIFO non-empty: pop, tx_data<=0 → START. No idle gap.
  - FIFO empty: → IDLE, tx_busy<=0.
- Parity: even = XOR of the DATABITS data bits; odd = its inverse.
- Frame length = 1 + DATABITS + (parity?1:0) + (stop2?2:1) bit periods.
- Config inputs are ignored mid-frame.

## Timing
- Reset values: tx_data=1, tx_busy=0, s_ready=1, fifo_count=0, state IDLE, FIFO flushed.
- Reset mid-frame aborts the frame: the line returns to 1 on the next clock, and queued words are discarded.
- First start bit appears on the first baud_tick that sees a non-empty FIFO registered. A push on the same clock as that tick waits for the next tick.
- Simultaneous push and pop in one clock: fifo_count is unchanged, and data order is preserved.
- When full, s_ready=0 and s_data must be held by the source. When empty, no pop occurs.
- tx_busy rises on the clock edge where tx_data first goes 0 and falls with the last stop-bit period's end.
- fifo_count and s_ready are updated one clock after the push or pop edge.

## Configuration
- Macro: UART_TX_BREAK_EN.
- Defined: the break_req port and BREAK state exist.
  - In IDLE, or at end of frame, a tick with break_req=1 takes priority over the FIFO: tx_data<=0 → BREAK, tx_busy=1.
  - BREAK holds the line low while break_req=1.
  - The first tick with break_req=0 sets tx_data<=1 → STOP1, which guarantees at least one high bit period, then follows normal end-of-frame.
- Undefined: no port and no BREAK state; behaviour is otherwise identical.

## Structure
- Package uart_pkg holds:
  - parity_mode_e (NONE/EVEN/ODD)
  - tx_state_e
  - the parity_mode encodings
- Sub-module sync_fifo is parametrised by width and depth.
  - It has push/pop/full/empty/count.
  - Its read data is valid combinationally when not empty.
  - It should be shared with the future RX FIFO.
- The FSM, the frame-config latch and the shift/index logic stay in uart_tx_fifo.

## Test plan
Bench settings: DATABITS=8, FIFO_DEPTH=4, baud_tick every 4 clks.

- **Reset idle:** hold reset 3 clks, release, run 10 ticks → tx_data=1, tx_busy=0, s_ready=1, fifo_count=0.
- **Even parity frame:** push 0x55, parity_mode=01, stop2=0 → line per tick 0,1,0,1,0,1,0,1,0,0,1. That is 11 periods, then tx_busy=0.
- **Odd parity, two stops:** push 0xA3, parity_mode=10, stop2=1 → 0,1,1,0,0,0,1,0,1,1,1,1. That is 12 periods with parity=1.
- **Backpressure and back-to-back:** push 5 words 0x01..0x05 between ticks.
  - s_ready drops after the 4th and the 5th is held.
  - All 5 words are sent in order, with each start bit directly following the previous stop bit.
- **Reset mid-frame:** assert reset during DATA idx=3 of 0xF0 with 2 words queued → tx_data=1 next clk, fifo_count=0, tx_busy=0, no further frames.
- **Break (UART_TX_BREAK_EN):**
  - With 0x33 queued, hold break_req for 20 ticks from idle → line low for 20 periods, tx_busy=1.
  - Release → at least 1 high period, then the 0x33 frame is sent.
